brightness_ctrl: RTL and testbench

Sequences the 8-bit LED brightness value from the four active-low board pushbuttons. It replaces ad-hoc clock-divider stepping with synchronised, debounced key sampling, a press/hold/auto-repeat state machine and fixed-priority command arbitration. Its `brightness` output feeds the hex-digit display decoder and the LED PWM stage in the `shifter` top level.

---
 rtl/brightness_pkg.sv | 49 ++++
 rtl/brightness_key_debounce.sv | 44 ++++
 rtl/brightness_ctrl.sv | 129 ++++++++++++
 tb/tb_brightness_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brightness_pkg.sv
// Shared types and helpers for the pushbutton-driven brightness controller.
// Commands, FSM states, level limits and the saturating step function.
package brightness_pkg;

    typedef enum logic [2:0] {
        NONE,
        UP,
        DOWN,
        PRESET_MAX,
        PRESET_ZERO
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_e;

    localparam logic [7:0] BRIGHT_MAX = 8'd255;
    localparam logic [7:0] BRIGHT_MIN = 8'd0;

    localparam int NUM_KEYS = 4;
    localparam int KEY_UP   = 3;
    localparam int KEY_DOWN = 2;
    localparam int KEY_MAX  = 1;
    localparam int KEY_ZERO = 0;

    // Widen to 9 bits so over/underflow shows up in bit 8 and can saturate.
    function automatic logic [7:0] apply_cmd(input cmd_e cmd, input logic [7:0] cur,
                                             input logic [7:0] step);
        logic [8:0] wide;
        wide      = 9'd0;
        apply_cmd = cur;
        case (cmd)
            UP: begin
                wide      = {1'b0, cur} + {1'b0, step};
                apply_cmd = wide[8] ? BRIGHT_MAX : wide[7:0];
            end
            DOWN: begin
                wide      = {1'b0, cur} - {1'b0, step};
                apply_cmd = wide[8] ? BRIGHT_MIN : wide[7:0];
            end
            PRESET_MAX:  apply_cmd = BRIGHT_MAX;
            PRESET_ZERO: apply_cmd = BRIGHT_MIN;
            default:     apply_cmd = cur;
        endcase
    endfunction

endpackage

// File: rtl/brightness_key_debounce.sv
// One pushbutton: 2-flop synchroniser followed by a tick-sampled debouncer.
// The stable level only moves after DEBOUNCE_TICKS matching samples of a candidate.
module key_debounce
    import brightness_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic key_raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]    sync;
    logic          candidate;
    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync      <= 2'b11;
            candidate <= 1'b1;
            count     <= '0;
            stable    <= 1'b1;
        end else begin
            sync <= {sync[0], key_raw};
            if (tick) begin
                if (sync[1] == candidate) begin
                    // Count saturates so a long-held level never wraps back.
                    if (count < CW'(DEBOUNCE_TICKS))
                        count <= count + 1'b1;
                    if (count >= CW'(DEBOUNCE_TICKS - 1))
                        stable <= candidate;
                end else begin
                    candidate <= sync[1];
                    count     <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/brightness_ctrl.sv
// LED brightness sequencer: debounced keys, fixed-priority arbitration and a
// press/hold/auto-repeat FSM driving a saturating 8-bit brightness register.
module brightness_ctrl
    import brightness_pkg::*;
#(
    parameter int TICK_DIV           = 50000,
    parameter int DEBOUNCE_TICKS     = 20,
    parameter int REPEAT_DELAY_TICKS = 500,
    parameter int REPEAT_RATE_TICKS  = 50,
    parameter int STEP               = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key,
    output logic [7:0] brightness,
    output logic       changed,
    output logic       at_limit
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                   : REPEAT_RATE_TICKS;
    localparam int HW = $clog2(HMAX + 1);
    localparam logic [7:0] STEP_V = 8'(STEP);

    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [NUM_KEYS-1:0]   stable;
    logic [NUM_KEYS-1:0]   pressed;
    cmd_e                  cmd;
    cmd_e                  cur_cmd;
    state_e                state;
    logic [HW-1:0]         hold_cnt;
    logic [7:0]            next_val;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_deb (
            .clock  (clock),
            .reset  (reset),
            .tick   (tick),
            .key_raw(key[i]),
            .stable (stable[i])
        );
    end

    assign pressed = ~stable;

    // Presets outrank stepping; opposing step keys cancel each other.
    always_comb begin
        cmd = NONE;
        if (pressed[KEY_MAX])
            cmd = PRESET_MAX;
        else if (pressed[KEY_ZERO])
            cmd = PRESET_ZERO;
        else if (pressed[KEY_UP] && !pressed[KEY_DOWN])
            cmd = UP;
        else if (pressed[KEY_DOWN] && !pressed[KEY_UP])
            cmd = DOWN;
    end

    assign next_val = apply_cmd(cmd, brightness, STEP_V);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cur_cmd    <= NONE;
            hold_cnt   <= '0;
            brightness <= BRIGHT_MAX;
            changed    <= 1'b0;
        end else begin
            changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd != NONE) begin
                        brightness <= next_val;
                        changed    <= (next_val != brightness);
                        cur_cmd    <= cmd;
                        hold_cnt   <= '0;
                        state      <= HELD;
                    end
                end
                HELD: begin
                    if (cmd != cur_cmd) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (hold_cnt == HW'(REPEAT_DELAY_TICKS - 1)) begin
                            brightness <= next_val;
                            changed    <= (next_val != brightness);
                            hold_cnt   <= '0;
                            state      <= REPEAT;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (cmd != cur_cmd) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (hold_cnt == HW'(REPEAT_RATE_TICKS - 1)) begin
                            brightness <= next_val;
                            changed    <= (next_val != brightness);
                            hold_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign at_limit = (brightness == BRIGHT_MIN) || (brightness == BRIGHT_MAX);

endmodule

// File: tb/tb_brightness_ctrl.sv
// Bench for brightness_ctrl: per-cycle comparison against a behavioural model
// (sample run-lengths, hold-time arithmetic) plus directed literal expectations.
module tb_brightness_ctrl;

    localparam int TICK_DIV           = 4;
    localparam int DEBOUNCE_TICKS     = 2;
    localparam int REPEAT_DELAY_TICKS = 8;
    localparam int REPEAT_RATE_TICKS  = 2;
    localparam int STEP               = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key   = 4'hF;
    logic [7:0] brightness;
    logic       changed;
    logic       at_limit;

    brightness_ctrl #(
        .TICK_DIV          (TICK_DIV),
        .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
        .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
        .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS),
        .STEP              (STEP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key       (key),
        .brightness(brightness),
        .changed   (changed),
        .at_limit  (at_limit)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_t[$];

    // Model state. Commands: 0 none, 1 up, 2 down, 3 preset max, 4 preset zero.
    bit         mvalid = 1'b0;
    int         ph, held, held_ticks, b_m, chg_m;
    logic [3:0] s0, s1, stab_m, run_val;
    int         run_len[4];

    function automatic int arb(input logic [3:0] p);
        if (p[1]) return 3;
        if (p[0]) return 4;
        if (p[3] && !p[2]) return 1;
        if (p[2] && !p[3]) return 2;
        return 0;
    endfunction

    function automatic int level_after(input int c, input int b);
        case (c)
            1: return (b + STEP > 255) ? 255 : b + STEP;
            2: return (b - STEP < 0) ? 0 : b - STEP;
            3: return 255;
            4: return 0;
            default: return b;
        endcase
    endfunction

    task automatic model_apply(input int c);
        int nb;
        nb    = level_after(c, b_m);
        chg_m = (nb != b_m) ? 1 : 0;
        b_m   = nb;
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_edge();
        bit tk;
        int c;
        if (reset) begin
            mvalid = 1'b1;
            ph = 0; held = 0; held_ticks = 0; b_m = 255; chg_m = 0;
            s0 = 4'hF; s1 = 4'hF; stab_m = 4'hF; run_val = 4'hF;
            for (int i = 0; i < 4; i++) run_len[i] = 1;
        end else if (mvalid) begin
            tk    = (ph == TICK_DIV - 1);
            c     = arb(~stab_m);
            chg_m = 0;
            if (held == 0) begin
                if (c != 0) begin
                    model_apply(c);
                    held = c;
                    held_ticks = 0;
                end
            end else if (c != held) begin
                held = 0;
            end else if (tk) begin
                held_ticks++;
                if (held_ticks >= REPEAT_DELAY_TICKS &&
                    (held_ticks - REPEAT_DELAY_TICKS) % REPEAT_RATE_TICKS == 0)
                    model_apply(held);
            end
            if (tk) begin
                for (int i = 0; i < 4; i++) begin
                    if (s1[i] == run_val[i]) run_len[i]++;
                    else begin
                        run_val[i] = s1[i];
                        run_len[i] = 1;
                    end
                    if (run_len[i] >= DEBOUNCE_TICKS + 1) stab_m[i] = run_val[i];
                end
            end
            s1 = s0;
            s0 = key;
            ph = (ph + 1) % TICK_DIV;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clock);
        cyc++;
        if (mvalid) begin
            check("brightness", 32'(brightness), 32'(b_m));
            check("changed", 32'(changed), 32'(chg_m));
            check("at_limit", 32'(at_limit), (b_m == 0 || b_m == 255) ? 32'd1 : 32'd0);
        end
        if (changed === 1'b1) pulse_t.push_back(cyc);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic [3:0] k, input int hold_ticks, input int settle_ticks);
        key = k;
        steps(hold_ticks * TICK_DIV);
        key = 4'hF;
        steps(settle_ticks * TICK_DIV);
    endtask

    initial begin
        int guard;
        int b_before;

        reset = 1'b1;
        key   = 4'hF;
        steps(3);
        reset = 1'b0;
        check("reset_brightness", 32'(brightness), 32'd255);
        check("reset_at_limit", 32'(at_limit), 32'd1);
        check("reset_changed", 32'(changed), 32'd0);

        // Single press of DOWN from 255.
        pulse_t.delete();
        press(4'b1011, 4, 8);
        check("single_down_value", 32'(brightness), 32'd254);
        check("single_down_pulses", 32'(pulse_t.size()), 32'd1);

        // Saturation at 255 through the delay and several repeats.
        press(4'b1101, 4, 8);
        pulse_t.delete();
        press(4'b0111, 25, 8);
        check("sat_max_value", 32'(brightness), 32'd255);
        check("sat_max_pulses", 32'(pulse_t.size()), 32'd0);

        // Saturation at 0.
        press(4'b1110, 4, 8);
        pulse_t.delete();
        press(4'b1011, 25, 8);
        check("sat_min_value", 32'(brightness), 32'd0);
        check("sat_min_pulses", 32'(pulse_t.size()), 32'd0);

        // Climb near 100, then single taps to land on it exactly.
        key = 4'b0111;
        guard = 0;
        while (brightness < 8'd90 && guard < 2000) begin
            step();
            guard++;
        end
        check("climb_timeout", (guard < 2000) ? 32'd1 : 32'd0, 32'd1);
        key = 4'hF;
        steps(8 * TICK_DIV);
        for (int i = 0; i < 30; i++) begin
            if (brightness < 8'd100) press(4'b0111, 4, 8);
            else if (brightness > 8'd100) press(4'b1011, 4, 8);
        end
        check("reach_100", 32'(brightness), 32'd100);

        // Auto-repeat spacing: the first repeat is 8 ticks after the initial step,
        // less the one IDLE cycle that applies it (31 cycles); later repeats 2 ticks.
        pulse_t.delete();
        key = 4'b1011;
        guard = 0;
        while (pulse_t.size() == 0 && guard < 100) begin
            step();
            guard++;
        end
        check("repeat_start_timeout", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
        steps((REPEAT_DELAY_TICKS + 10) * TICK_DIV);
        key = 4'hF;
        steps(8 * TICK_DIV);
        if (pulse_t.size() >= 4) begin
            check("repeat_gap_first", 32'(pulse_t[1] - pulse_t[0]), 32'd31);
            check("repeat_gap_second", 32'(pulse_t[2] - pulse_t[1]), 32'd8);
            check("repeat_gap_third", 32'(pulse_t[3] - pulse_t[2]), 32'd8);
        end else begin
            check("repeat_pulse_count", 32'(pulse_t.size()), 32'd4);
        end
        check("repeat_value", 32'(brightness), 32'(100 - pulse_t.size()));

        // Glitch of one tick on UP is ignored.
        b_before = b_m;
        pulse_t.delete();
        key = 4'b0111;
        steps(TICK_DIV);
        key = 4'hF;
        steps(8 * TICK_DIV);
        check("glitch_pulses", 32'(pulse_t.size()), 32'd0);
        check("glitch_value", 32'(brightness), 32'(b_before));

        // Bounce 1-0-1-0 then steady 0: exactly one step.
        pulse_t.delete();
        key = 4'b1111; steps(TICK_DIV);
        key = 4'b0111; steps(TICK_DIV);
        key = 4'b1111; steps(TICK_DIV);
        key = 4'b0111; steps(6 * TICK_DIV);
        key = 4'hF;    steps(8 * TICK_DIV);
        check("bounce_pulses", 32'(pulse_t.size()), 32'd1);
        check("bounce_value", 32'(brightness), 32'(b_before + 1));

        // UP and DOWN together cancel.
        b_before = b_m;
        pulse_t.delete();
        press(4'b0011, 12, 8);
        check("updown_pulses", 32'(pulse_t.size()), 32'd0);
        check("updown_value", 32'(brightness), 32'(b_before));

        // Preset zero overrides a held UP.
        key = 4'b0111;
        steps(5 * TICK_DIV);
        key = 4'b0110;
        steps(6 * TICK_DIV);
        check("zero_over_up", 32'(brightness), 32'd0);
        key = 4'hF;
        steps(8 * TICK_DIV);

        // Preset max wins over preset zero.
        press(4'b1100, 6, 8);
        check("max_over_zero", 32'(brightness), 32'd255);

        // Reset in the middle of an UP repeat at 50.
        press(4'b1110, 4, 8);
        key = 4'b0111;
        guard = 0;
        while (brightness != 8'd50 && guard < 2000) begin
            step();
            guard++;
        end
        check("reach_50_timeout", (guard < 2000) ? 32'd1 : 32'd0, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrepeat_reset_value", 32'(brightness), 32'd255);
        check("midrepeat_reset_changed", 32'(changed), 32'd0);
        pulse_t.delete();
        steps(15 * TICK_DIV);
        key = 4'hF;
        steps(8 * TICK_DIV);
        check("midrepeat_pulses", 32'(pulse_t.size()), 32'd0);
        check("midrepeat_value", 32'(brightness), 32'd255);

        // Randomised key activity against the model.
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: key = 4'($urandom_range(0, 15));
                1: key = 4'b0111;
                2: key = 4'b1011;
                3: key = 4'b1101;
                4: key = 4'b1110;
                default: key = 4'hF;
            endcase
            steps($urandom_range(1, 14) * TICK_DIV + $urandom_range(0, 3));
        end
        key = 4'hF;
        steps(10 * TICK_DIV);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
